// File: rtl/mmio_console_if.sv
// rtl/mmio_console_if.sv - core request/response and host tx stream bundle for mmio_console
interface mmio_console_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, tx_ready,
        input  req_ready, resp_valid, resp_rdata, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, tx_ready,
        output req_ready, resp_valid, resp_rdata, tx_valid, tx_data
    );
endinterface

// File: rtl/mmio_console.sv
// rtl/mmio_console.sv - MMIO console FIFO, status and exit registers with paced tx drain
module mmio_console #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_1000,
    parameter int              FIFO_DEPTH = 8,
    parameter int              DRAIN_GAP  = 2
) (
    input  logic            clk,
    input  logic            reset,
    mmio_console_if.slave   bus,
    output logic            halted,
    output logic [XLEN-1:0] exit_code,
    output logic            addr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (DRAIN_GAP > 1) ? $clog2(DRAIN_GAP) : 1;
    localparam logic [GW-1:0]   GAP_INIT     = GW'((DRAIN_GAP > 0) ? DRAIN_GAP - 1 : 0);
    localparam logic [XLEN-1:0] ADDR_CONSOLE = BASE_ADDR;
    localparam logic [XLEN-1:0] ADDR_STATUS  = BASE_ADDR + XLEN'(4);
    localparam logic [XLEN-1:0] ADDR_EXIT    = BASE_ADDR + XLEN'(8);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} drain_state_e;

    drain_state_e    state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            empty, full;
    logic            sel_console, sel_status, sel_exit, addr_ok;
    logic            ready, accept, push, pop, tx_valid;
    logic            armed;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q, load_data, status_word;

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));

    // Exact-match decode also rejects misaligned addresses inside the window.
    assign sel_console = (bus.req_addr == ADDR_CONSOLE);
    assign sel_status  = (bus.req_addr == ADDR_STATUS);
    assign sel_exit    = (bus.req_addr == ADDR_EXIT);
    assign addr_ok     = sel_console | sel_status | sel_exit;

    // Full is taken from the registered count: a pop this cycle does not unblock a push.
    assign ready  = !halted && !(bus.req_we && sel_console && full);
    assign accept = bus.req_valid && ready;
    assign push   = accept && bus.req_we && sel_console;

    assign status_word = XLEN'({count, empty, full});

    always_comb begin
        load_data = '0;
        if (sel_status) begin
            load_data = status_word;
        end else if (sel_exit) begin
            load_data = exit_code;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.req_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        tx_valid = 1'b0;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (bus.tx_ready) begin
                    pop = 1'b1;
                    if (DRAIN_GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_INIT;
                    end else if (count == CW'(1) && !push) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            armed        <= 1'b0;
            exit_code    <= '0;
            halted       <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            resp_valid_q <= accept && !bus.req_we;
            resp_rdata_q <= (accept && !bus.req_we) ? load_data : '0;
            if (accept && bus.req_we && sel_exit) begin
                armed     <= 1'b1;
                exit_code <= bus.req_wdata;
            end
            // Halt only once every buffered character has left the drain FSM.
            if (armed && empty && state_q == S_IDLE) halted <= 1'b1;
            if (accept && !addr_ok) addr_err <= 1'b1;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.tx_valid   = tx_valid;
    assign bus.tx_data    = tx_valid ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_mmio_console.sv
// tb/tb_mmio_console.sv - self-checking bench for mmio_console
module tb_mmio_console;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int NV = 11;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } resp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        halted, addr_err;
    logic [31:0] exit_code;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    resp_exp_t   respq[$];
    logic [7:0]  txq[$];
    int          beat_cyc[$];
    vec_t        vecs[NV];

    mmio_console_if #(.XLEN(32)) ifc ();

    mmio_console #(
        .XLEN(32), .BASE_ADDR(BASE), .FIFO_DEPTH(8), .DRAIN_GAP(2)
    ) dut (
        .clk(clk), .reset(reset), .bus(ifc),
        .halted(halted), .exit_code(exit_code), .addr_err(addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor samples late in the low phase, after every driver update for the coming edge.
    initial forever begin
        @(negedge clk);
        #4;
        if (ifc.resp_valid) begin
            if (respq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected actual=%h required=none", ifc.resp_rdata);
            end else begin
                resp_exp_t e;
                e = respq.pop_front();
                chk("resp_rdata", ifc.resp_rdata, e.data);
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (ifc.tx_valid && ifc.tx_ready) begin
            beat_cyc.push_back(cyc);
            if (txq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected actual=%h required=none", ifc.tx_data);
            end else begin
                chk("tx_data", {24'h0, ifc.tx_data}, {24'h0, txq.pop_front()});
            end
        end
    end

    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd);
        int n;
        n = 0;
        ifc.req_valid = 1'b1;
        ifc.req_we    = we;
        ifc.req_addr  = addr;
        ifc.req_wdata = wdata;
        #1;
        while (!ifc.req_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ifc.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout actual=ready0 required=ready1 addr=%h", addr);
            ifc.req_valid = 1'b0;
            return;
        end
        if (!we) respq.push_back('{data: exp_rd, cyc: cyc + 1});
        else if (addr == BASE) txq.push_back(wdata[7:0]);
        @(negedge clk);
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (txq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(txq.size()), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b0, BASE,          32'h0,  32'h0, 1'b0};
        vecs[1]  = '{1'b0, BASE + 32'd4,  32'h0,  32'h2, 1'b0};
        vecs[2]  = '{1'b1, BASE + 32'd4,  32'hFF, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, BASE + 32'd8,  32'h0,  32'h0, 1'b0};
        vecs[4]  = '{1'b0, BASE + 32'd12, 32'h0,  32'h0, 1'b1};
        vecs[5]  = '{1'b1, BASE + 32'd2,  32'h41, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, BASE + 32'd4,  32'h0,  32'h2, 1'b1};
        vecs[7]  = '{1'b0, BASE - 32'd4,  32'h0,  32'h0, 1'b1};
        vecs[8]  = '{1'b1, BASE + 32'd1,  32'h42, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, BASE + 32'd6,  32'h0,  32'h0, 1'b1};
        vecs[10] = '{1'b0, BASE + 32'd4,  32'h0,  32'h2, 1'b1};

        ifc.req_valid = 1'b0;
        ifc.req_we    = 1'b0;
        ifc.req_addr  = '0;
        ifc.req_wdata = '0;
        ifc.tx_ready  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'h0, ifc.req_ready}, 32'd1);
        chk("rst_tx_valid", {31'h0, ifc.tx_valid}, 32'd0);
        chk("rst_resp_valid", {31'h0, ifc.resp_valid}, 32'd0);
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_addr_err", {31'h0, addr_err}, 32'd0);
        chk("rst_exit_code", exit_code, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_op(1'b0, BASE + 32'd4, 32'h0, 32'h2);

        // "Hi" drain: two gap cycles plus one IDLE cycle separate the beats.
        ifc.tx_ready = 1'b1;
        beat_cyc.delete();
        bus_op(1'b1, BASE, 32'h48, 32'h0);
        bus_op(1'b1, BASE, 32'h69, 32'h0);
        wait_drain(100);
        repeat (4) @(negedge clk);
        chk("hi_beat_count", 32'(beat_cyc.size()), 32'd2);
        if (beat_cyc.size() == 2) chk("hi_beat_spacing", 32'(beat_cyc[1] - beat_cyc[0]), 32'd4);
        bus_op(1'b0, BASE + 32'd4, 32'h0, 32'h2);

        // Fill to full with the sink stalled, then a blocked 9th store.
        ifc.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_op(1'b1, BASE, 32'h30 + 32'(i), 32'h0);
        bus_op(1'b0, BASE + 32'd4, 32'h0, 32'h21);
        ifc.req_valid = 1'b1;
        ifc.req_we    = 1'b1;
        ifc.req_addr  = BASE;
        ifc.req_wdata = 32'h39;
        #1;
        chk("full_block", {31'h0, ifc.req_ready}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("full_hold", {31'h0, ifc.req_ready}, 32'd0);
        end
        @(negedge clk);
        ifc.tx_ready = 1'b1;
        #1;
        chk("full_no_bypass", {31'h0, ifc.req_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("full_ready_after_pop", {31'h0, ifc.req_ready}, 32'd1);
        txq.push_back(8'h39);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        wait_drain(200);
        repeat (4) @(negedge clk);

        ifc.tx_ready = 1'b0;
        for (int i = 0; i < NV; i++) begin
            bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
            #1;
            chk($sformatf("vec%0d_addr_err", i), {31'h0, addr_err}, {31'h0, vecs[i].err});
        end
        repeat (4) @(negedge clk);
        chk("err_fifo_untouched", {31'h0, ifc.tx_valid}, 32'd0);

        // Async reset while a character is being offered.
        for (int i = 0; i < 4; i++) bus_op(1'b1, BASE, 32'h70 + 32'(i), 32'h0);
        repeat (2) @(negedge clk);
        chk("pre_rst_tx_valid", {31'h0, ifc.tx_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_tx_valid", {31'h0, ifc.tx_valid}, 32'd0);
        txq.delete();
        repeat (2) @(negedge clk);
        chk("rst_clears_addr_err", {31'h0, addr_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        bus_op(1'b0, BASE + 32'd4, 32'h0, 32'h2);
        beat_cyc.delete();
        ifc.tx_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_stale_tx", 32'(beat_cyc.size()), 32'd0);

        // Exit with characters still queued.
        ifc.tx_ready = 1'b0;
        bus_op(1'b1, BASE, 32'h61, 32'h0);
        bus_op(1'b1, BASE, 32'h62, 32'h0);
        bus_op(1'b1, BASE, 32'h63, 32'h0);
        bus_op(1'b1, BASE + 32'd8, 32'h55, 32'h0);
        #1;
        chk("exit_code_first", exit_code, 32'h55);
        bus_op(1'b0, BASE + 32'd8, 32'h0, 32'h55);
        bus_op(1'b1, BASE + 32'd8, 32'h0, 32'h0);
        #1;
        chk("exit_code_overwrite", exit_code, 32'h0);
        repeat (3) @(negedge clk);
        chk("armed_not_halted", {31'h0, halted}, 32'd0);
        ifc.tx_ready = 1'b1;
        n = 0;
        while (!halted && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("halted", {31'h0, halted}, 32'd1);
        chk("halt_after_drain", 32'(txq.size()), 32'd0);
        chk("halt_tx_valid", {31'h0, ifc.tx_valid}, 32'd0);
        chk("halt_exit_code", exit_code, 32'h0);
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_we    = 1'b0;
        ifc.req_addr  = BASE + 32'd4;
        #1;
        chk("halt_req_ready", {31'h0, ifc.req_ready}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("halt_req_ready_hold", {31'h0, ifc.req_ready}, 32'd0);
        end
        ifc.req_valid = 1'b0;
        chk("halt_sticky", {31'h0, halted}, 32'd1);

        repeat (3) @(negedge clk);
        chk("respq_empty", 32'(respq.size()), 32'd0);
        chk("txq_empty", 32'(txq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
